// File: rtl/float_pack.sv
// ============================================================================
//  Package     : float_pack
//  Description : Opcode encodings and FSM state type for the FP coprocessor issuer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package float_pack;

    // Operation select lives in req_opcode[1:0]; upper bits pass through untouched.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage : float_pack

`default_nettype wire

// File: rtl/float_copro_issuer.sv
// ============================================================================
//  Module      : float_copro_issuer
//  Description : Issues one FP command to a coprocessor, holds it stable until
//                complete, then presents the captured result downstream.
//                Optional watchdog enabled by macro COPRO_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module float_copro_issuer
    import float_pack::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [10:0] req_opcode,
    input  logic [31:0] req_op0,
    input  logic [31:0] req_op1,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_error,

    output logic        busy,

    output logic        copro_valid,
    output logic [10:0] copro_opcode,
    output logic [31:0] copro_op0,
    output logic [31:0] copro_op1,
    input  logic        copro_complete,
    input  logic [31:0] copro_result
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_timeout_range_check
        $error("float_copro_issuer: TIMEOUT_CYCLES must be within 2..1023");
    end

    state_t state;

`ifdef COPRO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;
`else
    assign resp_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            copro_valid  <= 1'b0;
            copro_opcode <= '0;
            copro_op0    <= '0;
            copro_op1    <= '0;
            resp_valid   <= 1'b0;
            resp_result  <= '0;
`ifdef COPRO_TIMEOUT_EN
            resp_error   <= 1'b0;
            tmo_cnt      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // copro_complete is deliberately not looked at here.
                    if (req_valid) begin
                        copro_opcode <= req_opcode;
                        copro_op0    <= req_op0;
                        copro_op1    <= req_op1;
                        copro_valid  <= 1'b1;
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ST_ISSUE;
`ifdef COPRO_TIMEOUT_EN
                        tmo_cnt      <= '0;
`endif
                    end
                end

                ST_ISSUE: begin
                    if (copro_complete) begin
                        resp_result <= copro_result;
                        copro_valid <= 1'b0;
                        resp_valid  <= 1'b1;
                        state       <= ST_RESP;
`ifdef COPRO_TIMEOUT_EN
                        resp_error  <= 1'b0;
`endif
                    end
`ifdef COPRO_TIMEOUT_EN
                    // Complete wins over a timeout landing on the same edge.
                    else if (tmo_cnt == TMO_LAST) begin
                        resp_result <= '0;
                        resp_error  <= 1'b1;
                        copro_valid <= 1'b0;
                        resp_valid  <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        tmo_cnt     <= tmo_cnt + 1'b1;
                    end
`endif
                end

                ST_RESP: begin
                    // Returning to IDLE (not straight to ISSUE) guarantees a
                    // low cycle on copro_valid to re-arm the coprocessor.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    req_ready   <= 1'b1;
                    busy        <= 1'b0;
                    copro_valid <= 1'b0;
                    resp_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule : float_copro_issuer

`default_nettype wire

// File: tb/tb_float_copro_issuer.sv
// ============================================================================
//  Module      : tb_float_copro_issuer
//  Description : Directed bench for float_copro_issuer with a behavioural
//                coprocessor model (add/sub 5, mul 4, div 40 cycles).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_float_copro_issuer;
    import float_pack::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_opcode;
    logic [31:0] req_op0;
    logic [31:0] req_op1;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        resp_error;
    logic        busy;
    logic        copro_valid;
    logic [10:0] copro_opcode;
    logic [31:0] copro_op0;
    logic [31:0] copro_op1;
    logic        copro_complete;
    logic [31:0] copro_result;

    always #5 clk = ~clk;

    float_copro_issuer #(.TIMEOUT_CYCLES(64)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opcode     (req_opcode),
        .req_op0        (req_op0),
        .req_op1        (req_op1),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_result    (resp_result),
        .resp_error     (resp_error),
        .busy           (busy),
        .copro_valid    (copro_valid),
        .copro_opcode   (copro_opcode),
        .copro_op0      (copro_op0),
        .copro_op1      (copro_op1),
        .copro_complete (copro_complete),
        .copro_result   (copro_result)
    );

    // ---------------- behavioural coprocessor ----------------
    logic        model_hang = 1'b0;
    logic        force_cpl  = 1'b0;
    logic        m_cpl;
    logic [31:0] m_res;
    int          m_cnt;

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            OP_MUL:  return 4;
            OP_DIV:  return 40;
            default: return 5;
        endcase
    endfunction

    // Small table of known single-precision results.
    function automatic logic [31:0] fp_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == OP_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (op == OP_ADD && a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4080_0000;
        if (op == OP_SUB && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
        if (op == OP_MUL && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        if (op == OP_MUL && a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (op == OP_DIV && a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt <= 0;
            m_cpl <= 1'b0;
            m_res <= '0;
        end else if (!copro_valid) begin
            m_cnt <= 0;
            m_cpl <= 1'b0;
        end else if (!m_cpl && !model_hang) begin
            if (m_cnt + 1 == lat_of(copro_opcode[1:0])) begin
                m_cpl <= 1'b1;
                m_res <= fp_model(copro_opcode[1:0], copro_op0, copro_op1);
            end
            m_cnt <= m_cnt + 1;
        end
    end

    assign copro_complete = m_cpl | force_cpl;
    assign copro_result   = m_res;

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_resp();
        int guard = 0;
        while (!resp_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("resp_arrived", {31'd0, resp_valid}, 32'd1);
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_op(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic exp_err, input int hold, input int vh);
        int          cnt   = 0;
        int          guard = 0;
        bit          bad   = 1'b0;
        logic [31:0] held;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_opcode = opc; req_op0 = a; req_op1 = b;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        while (!resp_valid && guard < 200) begin
            if (copro_valid) begin
                cnt++;
                if (copro_opcode !== opc || copro_op0 !== a || copro_op1 !== b) bad = 1'b1;
            end
            guard++;
            @(negedge clk);
        end
        check("resp_arrived",  {31'd0, resp_valid}, 32'd1);
        check("valid_cycles",  cnt, vh);
        check("operands_held", {31'd0, bad}, 32'd0);
        check("resp_result",   resp_result, exp);
        check("resp_error",    {31'd0, resp_error}, {31'd0, exp_err});
        check("resp_state",    {29'd0, copro_valid, req_ready, busy}, 32'd1);
        held = resp_result;
        bad  = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (resp_result !== held || !resp_valid || req_ready) bad = 1'b1;
        end
        check("resp_hold", {31'd0, bad}, 32'd0);
        handshake();
        check("after_handshake", {28'd0, resp_valid, req_ready, busy, copro_valid}, 32'h4);
        check("opcode_retained", {21'd0, copro_opcode}, {21'd0, opc});
    endtask

    typedef struct {
        logic [10:0] opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          hold;
        int          vh;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;

        // Back-to-back mul then div appear as entries 1 and 2.
        vecs[0] = '{{9'd0, OP_ADD}, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 6};
        vecs[1] = '{{9'd0, OP_MUL}, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 0, 5};
        vecs[2] = '{{9'd0, OP_DIV}, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 41};
        vecs[3] = '{{9'd0, OP_SUB}, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 2, 6};
        vecs[4] = '{11'h7FC,        32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 0, 6};
        vecs[5] = '{{9'd0, OP_MUL}, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1, 5};

        reset_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_op0 = '0; req_op1 = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_ctrl",   {27'd0, req_ready, copro_valid, resp_valid, busy, resp_error}, 32'h10);
        check("reset_result", resp_result, 32'd0);
        check("reset_copro",  copro_op0 | copro_op1 | {21'd0, copro_opcode}, 32'd0);

        foreach (vecs[i])
            do_op(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, vecs[i].hold, vecs[i].vh);

        // Back-pressure with the next request already offered.
        req_valid = 1'b1; req_opcode = {9'd0, OP_ADD}; req_op0 = 32'h3F80_0000; req_op1 = 32'h4000_0000;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        wait_resp();
        req_valid = 1'b1; req_opcode = {9'd0, OP_SUB}; req_op0 = 32'h4040_0000; req_op1 = 32'h3F80_0000;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!resp_valid || req_ready || copro_valid || resp_result !== 32'h4040_0000) bad = 1'b1;
        end
        check("backpressure_hold", {31'd0, bad}, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
        @(negedge clk);
        check("no_accept_on_handshake", {29'd0, resp_valid, req_ready, copro_valid}, 32'h2);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("accept_next_valid", {31'd0, copro_valid}, 32'd1);
        check("accept_next_op0",   copro_op0, 32'h4040_0000);
        wait_resp();
        check("accept_next_result", resp_result, 32'h4000_0000);
        handshake();

        // Spurious complete while idle.
        force_cpl = 1'b1;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || busy || !req_ready) bad = 1'b1;
        end
        force_cpl = 1'b0;
        check("idle_complete_ignored", {31'd0, bad}, 32'd0);
        @(negedge clk);

`ifdef COPRO_TIMEOUT_EN
        model_hang = 1'b1;
        do_op({9'd0, OP_ADD}, 32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b1, 0, 64);
        model_hang = 1'b0;
        do_op({9'd0, OP_ADD}, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 0, 6);
`else
        model_hang = 1'b1;
        req_valid = 1'b1; req_opcode = {9'd0, OP_ADD}; req_op0 = 32'h3F80_0000; req_op1 = 32'h4000_0000;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (100) @(negedge clk);
        check("no_timeout_wait", {30'd0, copro_valid, resp_valid}, 32'h2);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_hang = 1'b0;
        @(negedge clk);
`endif

        // Reset pulse in the middle of a long divide.
        req_valid = 1'b1; req_opcode = {9'd0, OP_DIV}; req_op0 = 32'h40C0_0000; req_op1 = 32'h4000_0000;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("div_in_flight", {31'd0, copro_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_ctrl",   {28'd0, copro_valid, resp_valid, busy, resp_error}, 32'd0);
        check("async_reset_result", resp_result, 32'd0);
        check("async_reset_copro",  copro_op0 | copro_op1 | {21'd0, copro_opcode}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (resp_valid || busy || copro_valid) bad = 1'b1;
        end
        check("no_resp_after_reset", {31'd0, bad}, 32'd0);
        do_op({9'd0, OP_DIV}, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 0, 41);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_float_copro_issuer

`default_nettype wire
